alu_load_sequencer: RTL and testbench
=====================================

// Module: alu_load_sequencer
// PURPOSE
//  Button-driven FSM that loads the ALU operand A, operand B and control registers in turn.
//  Each load is a one-cycle enable pulse to an enable-gated 4-bit register; data comes from the switches.
//  After the control load it waits for the ALU to settle, captures result/flags and holds them for display.
//  Sits between board I/O (button, clear) and the ALU register bank.
// PARAMETERS
//  WIDTH            4   ALU data width (result bus)
//  EXEC_CYCLES      2   cycles spent in EXEC before capture; legal range >= 2
//  DEBOUNCE_CYCLES  16  stable-sample count for debounce (used only with ALU_SEQ_DEBOUNCE_EN)
// PORTS
//  clock       in   1      system clock, all logic on rising edge
//  reset       in   1      synchronous, active-low reset
//  btn         in   1      asynchronous load push-button, active-high
//  clear       in   1      synchronous abort: return to LOAD_A, active-high
//  alu_result  in   WIDTH  ALU combinational result
//  alu_flags   in   4      ALU flags {C,Z,N,V}
//  en_a        out  1      load enable, operand A register
//  en_b        out  1      load enable, operand B register
//  en_ctrl     out  1      load enable, control register
//  result      out  WIDTH  captured ALU result
//  flags       out  4      captured ALU flags
//  state       out  3      current state code
//  busy        out  1      high while in EXEC
//  done        out  1      high while in SHOW
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=LOAD_A; en_a/en_b/en_ctrl=0; result=0; flags=0; done=0;
//    exec counter=0; btn synchronizer flops and btn_prev = 1, so a button held through reset gives no press.
//  - btn passes a 2-flop synchronizer -> btn_s. press = btn_s & ~btn_prev; btn_prev <= btn_s each cycle.
//  - State codes: LOAD_A=0, LOAD_B=1, LOAD_CTRL=2, EXEC=3, SHOW=4; codes 5-7 go to LOAD_A next cycle.
//  - LOAD_A + press -> en_a=1 for one cycle, go to LOAD_B. LOAD_B + press -> en_b=1, go to LOAD_CTRL.
//  - LOAD_CTRL + press -> en_ctrl=1, go to EXEC, exec counter = EXEC_CYCLES-1.
//  - EXEC: counter decrements each cycle; press ignored. At the edge where counter==0:
//    result<=alu_result, flags<=alu_flags, state=SHOW, done=1.
//    Capture happens EXEC_CYCLES edges after entry; the control register updates one edge after entry.
//  - SHOW + press -> LOAD_A, done=0. result/flags hold until the next capture.
//  - en_* are registered, mutually exclusive, and never high for more than one cycle per press.
//  - Latency: btn rises before edge N -> en_* high in the cycle after edge N+2 (3 edges).
//  - clear (when reset==1): next state LOAD_A from any state; en_*=0, done=0, counter=0; result/flags kept.
//    clear and press in the same cycle: clear wins and the press is discarded.
//  - reset wins over clear. Reset mid-EXEC: no capture; result returns to 0.
//  - busy = (state==EXEC); done = (state==SHOW), registered.
// CONFIGURATION
//  ALU_SEQ_DEBOUNCE_EN defined: btn_s feeds a debouncer.
//    btn_clean changes only after btn_s differs from it for DEBOUNCE_CYCLES consecutive cycles.
//    Any bounce restarts the count. press is derived from btn_clean (reset value 1).
//    Latency becomes 3+DEBOUNCE_CYCLES edges.
//  ALU_SEQ_DEBOUNCE_EN undefined: no debouncer, no debounce counter; press is derived directly from btn_s.
// TESTING
//  1. reset=0 for 2 cycles with btn=1, then release reset -> state=0, no en_* pulse, result=0, done=0.
//  2. 3 clean presses, alu_result=4'hA, flags=4'b0100 -> en_a, en_b, en_ctrl each pulse once, in order;
//     busy=1 for 2 cycles; then result=4'hA, flags=4'b0100, done=1, state=4.
//  3. In EXEC, pulse btn and hold 10 cycles -> no en_*, capture still at EXEC_CYCLES; a 4th press in SHOW -> state=0, done=0.
//  4. In LOAD_B, assert clear and press together -> state=0 next cycle, en_b never high; result unchanged.
//  5. Assert reset=0 during EXEC -> state=0, result=0, busy=0 next cycle, and no capture.
//  6. With ALU_SEQ_DEBOUNCE_EN: btn toggles every 3 cycles for 40 cycles, then is held high -> exactly one en_a pulse,
//     3+16 edges after the final rise.

Source files
------------

// File: rtl/alu_load_sequencer_if.sv
// Bus bundle between the ALU load sequencer, the board I/O and the ALU register bank.
// master: the sequencer (drives load enables and the captured result/status).
// slave : the environment (button, clear, ALU result/flags) that observes the sequencer.
interface alu_load_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             btn;
    logic             clear;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic             en_a;
    logic             en_b;
    logic             en_ctrl;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [2:0]       state;
    logic             busy;
    logic             done;

    modport master (
        input  btn, clear, alu_result, alu_flags,
        output en_a, en_b, en_ctrl, result, flags, state, busy, done
    );

    modport slave (
        output btn, clear, alu_result, alu_flags,
        input  en_a, en_b, en_ctrl, result, flags, state, busy, done
    );
endinterface

// File: rtl/alu_load_sequencer.sv
// alu_load_sequencer
// Button-driven FSM that loads ALU operand A, operand B and the control register
// in turn (one-cycle enable pulses), waits EXEC_CYCLES for the ALU to settle,
// then captures result/flags and holds them for display.
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN -- when defined, the synchronized
// button passes through a DEBOUNCE_CYCLES stable-sample debouncer before edge detect.
module alu_load_sequencer #(
    parameter int WIDTH           = 4,
    parameter int EXEC_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    alu_load_sequencer_if.master  bus
);

    // Wide enough to hold EXEC_CYCLES-1.
    localparam int CNT_W = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        LOAD_CTRL = 3'd2,
        EXEC      = 3'd3,
        SHOW      = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               en_a_r;
    logic               en_b_r;
    logic               en_ctrl_r;
    logic               en_a_nxt_s;
    logic               en_b_nxt_s;
    logic               en_ctrl_nxt_s;
    logic               capture_s;
    logic [WIDTH-1:0]   result_r;
    logic [3:0]         flags_r;
    logic               busy_r;
    logic               done_r;

    logic               btn_meta_r;
    logic               btn_sync_r;
    logic               btn_level_s;
    logic               btn_prev_r;
    logic               press_s;

    // Two-flop synchronizer; resets high so a button held through reset is not a press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
        end else begin
            btn_meta_r <= bus.btn;
            btn_sync_r <= btn_meta_r;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_r;
    logic            btn_clean_r;

    // Debouncer: accept a new level only after it has been stable for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_clean_r <= 1'b1;
            db_cnt_r    <= '0;
        end else if (btn_sync_r == btn_clean_r) begin
            db_cnt_r    <= '0;
        end else if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_clean_r <= btn_sync_r;
            db_cnt_r    <= '0;
        end else begin
            db_cnt_r    <= db_cnt_r + DB_W'(1);
        end
    end

    assign btn_level_s = btn_clean_r;
`else
    assign btn_level_s = btn_sync_r;
`endif

    // Previous button level for rising-edge detection; high after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            btn_prev_r <= 1'b1;
        end else begin
            btn_prev_r <= btn_level_s;
        end
    end

    assign press_s = btn_level_s & ~btn_prev_r;

    // Next-state and next-output logic; clear overrides everything including a press.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        en_a_nxt_s    = 1'b0;
        en_b_nxt_s    = 1'b0;
        en_ctrl_nxt_s = 1'b0;
        capture_s     = 1'b0;
        if (bus.clear) begin
            state_nxt_s = LOAD_A;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                LOAD_A: begin
                    if (press_s) begin
                        en_a_nxt_s  = 1'b1;
                        state_nxt_s = LOAD_B;
                    end else begin
                        state_nxt_s = LOAD_A;
                    end
                end
                LOAD_B: begin
                    if (press_s) begin
                        en_b_nxt_s  = 1'b1;
                        state_nxt_s = LOAD_CTRL;
                    end else begin
                        state_nxt_s = LOAD_B;
                    end
                end
                LOAD_CTRL: begin
                    if (press_s) begin
                        en_ctrl_nxt_s = 1'b1;
                        state_nxt_s   = EXEC;
                        cnt_nxt_s     = CNT_W'(EXEC_CYCLES - 1);
                    end else begin
                        state_nxt_s   = LOAD_CTRL;
                    end
                end
                EXEC: begin
                    // Button is ignored while the ALU settles.
                    if (cnt_r == '0) begin
                        capture_s   = 1'b1;
                        state_nxt_s = SHOW;
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (press_s) begin
                        state_nxt_s = LOAD_A;
                    end else begin
                        state_nxt_s = SHOW;
                    end
                end
                default: begin
                    state_nxt_s = LOAD_A;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // State, enables, status and captured result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= LOAD_A;
            cnt_r     <= '0;
            en_a_r    <= 1'b0;
            en_b_r    <= 1'b0;
            en_ctrl_r <= 1'b0;
            result_r  <= '0;
            flags_r   <= 4'b0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            en_a_r    <= en_a_nxt_s;
            en_b_r    <= en_b_nxt_s;
            en_ctrl_r <= en_ctrl_nxt_s;
            busy_r    <= (state_nxt_s == EXEC);
            done_r    <= (state_nxt_s == SHOW);
            if (capture_s) begin
                result_r <= bus.alu_result;
                flags_r  <= bus.alu_flags;
            end
        end
    end

    assign bus.en_a    = en_a_r;
    assign bus.en_b    = en_b_r;
    assign bus.en_ctrl = en_ctrl_r;
    assign bus.result  = result_r;
    assign bus.flags   = flags_r;
    assign bus.state   = state_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Self-checking bench for alu_load_sequencer: directed stimulus pushes expected
// enable/capture events into a scoreboard queue; a monitor pops and compares
// whenever the DUT pulses an enable or enters SHOW.
module tb_alu_load_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    alu_load_sequencer_if #(.WIDTH(4)) bus();

    alu_load_sequencer #(
        .WIDTH(4),
        .EXEC_CYCLES(2),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT = 3 + 16;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int         kind;   // 1=en_a 2=en_b 3=en_ctrl 4=capture
        logic [3:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic done_prev = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.kind = kind;
        e.res  = r;
        e.flg  = f;
        exp_q.push_back(e);
    endtask

    // Full press: expected enable pattern checked after LAT edges, then released.
    task automatic press(input int kind, input string name);
        logic [2:0] e;
        e = (kind == 1) ? 3'b100 : (kind == 2) ? 3'b010 : (kind == 3) ? 3'b001 : 3'b000;
        if (kind != 0) expect_ev(kind, 4'h0, 4'h0);
        bus.btn = 1'b1;
        tick(LAT);
        chk(name, 32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'(e));
        bus.btn = 1'b0;
        tick(LAT + 2);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clock) begin : monitor
        int   kind;
        exp_t e;
        kind = 0;
        if (bus.en_a)    kind = 1;
        if (bus.en_b)    kind = 2;
        if (bus.en_ctrl) kind = 3;
        if (bus.done === 1'b1 && done_prev !== 1'b1) kind = 4;
        done_prev = bus.done;
        if (kind != 0) begin
            checks++;
            if ($countones({bus.en_a, bus.en_b, bus.en_ctrl}) > 1) begin
                failures++;
                $display("FAIL en_onehot: got %b expected one-hot", {bus.en_a, bus.en_b, bus.en_ctrl});
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got kind %0d expected none", kind);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != kind) begin
                    failures++;
                    $display("FAIL event_order: got kind %0d expected kind %0d", kind, e.kind);
                end else if (kind == 4 && (bus.result !== e.res || bus.flags !== e.flg)) begin
                    failures++;
                    $display("FAIL capture: got result %h flags %b expected result %h flags %b",
                             bus.result, bus.flags, e.res, e.flg);
                end
            end
        end
    end

    initial begin
        bus.btn        = 1'b1;
        bus.clear      = 1'b0;
        bus.alu_result = 4'h0;
        bus.alu_flags  = 4'b0000;

        // 1: reset with button held high
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rst_state",  32'(bus.state), 32'd0);
        chk("rst_en",     32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags",  32'(bus.flags), 32'd0);
        chk("rst_done",   32'(bus.done), 32'd0);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        tick(LAT + 2);
        chk("held_btn_no_press", 32'(bus.state), 32'd0);
        bus.btn = 1'b0;
        tick(LAT + 2);

        // 2: full load/exec/show sequence
        bus.alu_result = 4'hA;
        bus.alu_flags  = 4'b0100;
        press(1, "t2_en_a");
        chk("t2_state_b", 32'(bus.state), 32'd1);
        press(2, "t2_en_b");
        chk("t2_state_ctrl", 32'(bus.state), 32'd2);
        expect_ev(3, 4'h0, 4'h0);
        expect_ev(4, 4'hA, 4'b0100);
        bus.btn = 1'b1;
        tick(LAT);
        chk("t2_en_ctrl", 32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'd1);
        chk("t2_busy1",   32'(bus.busy), 32'd1);
        chk("t2_exec",    32'(bus.state), 32'd3);
        bus.btn = 1'b0;
        tick(1);
        chk("t2_busy2",   32'(bus.busy), 32'd1);
        chk("t2_exec2",   32'(bus.state), 32'd3);
        tick(1);
        chk("t2_show",    32'(bus.state), 32'd4);
        chk("t2_done",    32'(bus.done), 32'd1);
        chk("t2_busy_off", 32'(bus.busy), 32'd0);
        chk("t2_result",  32'(bus.result), 32'hA);
        chk("t2_flags",   32'(bus.flags), 32'b0100);
        tick(LAT + 2);

        // 3: press during EXEC ignored, long hold in SHOW, 4th press exits
        press(0, "t3_show_exit");
        chk("t3_state0", 32'(bus.state), 32'd0);
        chk("t3_done0",  32'(bus.done), 32'd0);
        bus.alu_result = 4'h5;
        bus.alu_flags  = 4'b0011;
        press(1, "t3_en_a");
        press(2, "t3_en_b");
        expect_ev(3, 4'h0, 4'h0);
        expect_ev(4, 4'h5, 4'b0011);
        bus.btn = 1'b1;
        tick(LAT - 2);
        bus.btn = 1'b0;
        tick(1);
        bus.btn = 1'b1;
        tick(1);
        chk("t3_en_ctrl", 32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'd1);
        chk("t3_exec",    32'(bus.state), 32'd3);
        tick(2);
        chk("t3_show",    32'(bus.state), 32'd4);
        chk("t3_done",    32'(bus.done), 32'd1);
        chk("t3_result",  32'(bus.result), 32'h5);
        tick(8);
        chk("t3_hold_show", 32'(bus.state), 32'd4);
        bus.btn = 1'b0;
        tick(LAT + 2);
        press(0, "t3_exit");
        chk("t3_back_a",  32'(bus.state), 32'd0);
        chk("t3_done_lo", 32'(bus.done), 32'd0);

        // 4: clear and press together in LOAD_B
        press(1, "t4_en_a");
        chk("t4_state_b", 32'(bus.state), 32'd1);
        bus.btn = 1'b1;
        tick(LAT - 1);
        bus.clear = 1'b1;
        tick(1);
        chk("t4_clear_state", 32'(bus.state), 32'd0);
        chk("t4_no_en",       32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'd0);
        chk("t4_result_kept", 32'(bus.result), 32'h5);
        bus.clear = 1'b0;
        tick(1);
        chk("t4_no_en_after", 32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'd0);
        bus.btn = 1'b0;
        tick(LAT + 2);
        chk("t4_state_end", 32'(bus.state), 32'd0);

        // 5: reset in the middle of EXEC
        bus.alu_result = 4'hF;
        bus.alu_flags  = 4'b1111;
        press(1, "t5_en_a");
        press(2, "t5_en_b");
        expect_ev(3, 4'h0, 4'h0);
        bus.btn = 1'b1;
        tick(LAT);
        chk("t5_busy", 32'(bus.busy), 32'd1);
        reset   = 1'b0;
        bus.btn = 1'b0;
        tick(1);
        chk("t5_state", 32'(bus.state), 32'd0);
        chk("t5_result", 32'(bus.result), 32'd0);
        chk("t5_flags", 32'(bus.flags), 32'd0);
        chk("t5_busy0", 32'(bus.busy), 32'd0);
        chk("t5_done0", 32'(bus.done), 32'd0);
        reset = 1'b1;
        tick(6);
        chk("t5_no_capture", 32'(bus.done), 32'd0);

`ifdef ALU_SEQ_DEBOUNCE_EN
        // 6: bouncing button then a clean hold gives exactly one en_a
        for (int i = 0; i < 13; i++) begin
            bus.btn = ~bus.btn;
            tick(3);
        end
        bus.btn = 1'b0;
        tick(3);
        expect_ev(1, 4'h0, 4'h0);
        bus.btn = 1'b1;
        tick(LAT - 1);
        chk("t6_not_yet", 32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'd0);
        tick(1);
        chk("t6_en_a", 32'({bus.en_a, bus.en_b, bus.en_ctrl}), 32'b100);
        bus.btn = 1'b0;
        tick(LAT + 2);
        chk("t6_state_b", 32'(bus.state), 32'd1);
`endif

        tick(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
